qarma64_tweak_sched: RTL and testbench

- Iterative tweak-schedule generator for the QARMA-64 datapath.
- Accepts one 64-bit tweak per job and streams ROUNDS+1 successive round tweaks T0..T_ROUNDS to the round pipeline over a valid/ready handshake.
- Forward mode: each update is the tweak cell shuffle h followed by the cell LFSR omega.
- Inverse mode: omega^-1 followed by h^-1; used by the backward half and the decryption path.
- Sits directly upstream of the round-tweakey XOR that feeds the state ShuffleCells/MixColumns stages.

---
 rtl/qarma64_pkg.sv | 30 +++
 rtl/qarma64_tweak_update.sv | 37 +++
 rtl/qarma64_tweak_sched.sv | 108 ++++++++++
 tb/tb_qarma64_tweak_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/qarma64_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qarma64_pkg
// Brief   : Shared QARMA-64 tweak tables, cell type and LFSR helpers.
// Revision: 1.0 - initial release
// ============================================================================
package qarma64_pkg;

    // 16 cells of 4 bits; index 0 is the most significant nibble [63:60].
    typedef logic [0:15][3:0] cells_t;

    // Cell i of each table sits at bits [63-4*i -: 4]; value = source cell.
    localparam logic [63:0] PERM_H = 64'h65EF_0123_7CD4_89AB;
    localparam logic [63:0] INV_H  = 64'h4567_B108_CDEF_9A23;

    // Cells touched by the LFSR; cell 0 is bit 15.
    localparam logic [15:0] LFSR_MASK = 16'b1101_1000_1001_0100;

    // Forward cell LFSR: (b3,b2,b1,b0) -> (b0^b1, b3, b2, b1).
    function automatic logic [3:0] omega_fwd(input logic [3:0] c);
        return {c[0] ^ c[1], c[3], c[2], c[1]};
    endfunction

    // Inverse cell LFSR: (b3,b2,b1,b0) -> (b2, b1, b0, b3^b0).
    function automatic logic [3:0] omega_inv(input logic [3:0] c);
        return {c[2], c[1], c[0], c[3] ^ c[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qarma64_tweak_update.sv
`default_nettype none
// ============================================================================
// Module  : qarma64_tweak_update
// Brief   : One combinational tweak update step, forward (omega o h) or
//           inverse (h^-1 o omega^-1).
// Revision: 1.0 - initial release
// ============================================================================
module qarma64_tweak_update
    import qarma64_pkg::*;
(
    input  logic [63:0] tweak,
    input  logic        inverse,
    output logic [63:0] tweak_upd
);

    cells_t w_in;
    cells_t w_h;      // forward: after ShuffleCellsTweak
    cells_t w_fwd;    // forward: after LFSR cells
    cells_t w_oi;     // inverse: after inverse LFSR cells
    cells_t w_inv;    // inverse: after InvShuffleCellsTweak

    assign w_in = tweak;

    for (genvar i = 0; i < 16; i++) begin : g_cell
        localparam int c_src_h  = int'(PERM_H[63-4*i -: 4]);
        localparam int c_src_hi = int'(INV_H[63-4*i -: 4]);

        assign w_h[i]   = w_in[c_src_h];
        assign w_fwd[i] = LFSR_MASK[15-i] ? omega_fwd(w_h[i]) : w_h[i];
        assign w_oi[i]  = LFSR_MASK[15-i] ? omega_inv(w_in[i]) : w_in[i];
        assign w_inv[i] = w_oi[c_src_hi];
    end

    assign tweak_upd = inverse ? w_inv : w_fwd;

endmodule
`default_nettype wire

// File: rtl/qarma64_tweak_sched.sv
`default_nettype none
// ============================================================================
// Module  : qarma64_tweak_sched
// Brief   : Iterative QARMA-64 tweak schedule; streams T0..T_ROUNDS per job
//           over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module qarma64_tweak_sched
    import qarma64_pkg::*;
#(
    parameter int ROUNDS = 7,
    parameter int IDX_W  = (ROUNDS > 0) ? $clog2(ROUNDS + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_tweak,
    input  logic             in_inverse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_tweak,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ROUNDS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_tweak;
    logic             r_inv;
    logic [IDX_W-1:0] r_idx;
    logic [63:0]      w_tweak_upd;
    logic             w_accept;
    logic             w_step;
    logic             w_at_last;

    qarma64_tweak_update u_update (
        .tweak     (r_tweak),
        .inverse   (r_inv),
        .tweak_upd (w_tweak_upd)
    );

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_at_last   = (r_idx == c_last_idx);
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (w_at_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        out_last = w_at_last && out_valid;
    end

    // State, tweak register and round counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tweak <= '0;
            r_inv   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tweak <= in_tweak;
                r_inv   <= in_inverse;
                r_idx   <= '0;
            end else if (w_step) begin
                r_tweak <= w_tweak_upd;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign out_tweak = r_tweak;
    assign out_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_qarma64_tweak_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_qarma64_tweak_sched
// Brief   : Self-checking bench for qarma64_tweak_sched.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qarma64_tweak_sched;

    localparam int ROUNDS = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_tweak;
    logic        in_inverse;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_tweak;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    typedef logic [63:0] seq_t [ROUNDS+1];

    typedef struct {
        logic [63:0] tweak;
        logic        inv;
        int          k;
        logic [63:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    qarma64_tweak_sched #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tweak   (in_tweak),
        .in_inverse (in_inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tweak  (out_tweak),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Independent reference for one tweak update step.
    function automatic logic [63:0] ref_upd(input logic [63:0] t, input bit inv);
        int   ph [16] = '{6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11};
        int   ih [16] = '{4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3};
        bit   om [16] = '{1,1,0,1,1,0,0,0,1,0,0,1,0,1,0,0};
        logic [3:0] c [16];
        logic [3:0] d [16];
        logic [63:0] r;
        for (int i = 0; i < 16; i++) c[i] = t[63-4*i -: 4];
        if (!inv) begin
            for (int i = 0; i < 16; i++) d[i] = c[ph[i]];
            for (int i = 0; i < 16; i++)
                if (om[i]) d[i] = {d[i][0] ^ d[i][1], d[i][3:1]};
        end else begin
            for (int i = 0; i < 16; i++)
                if (om[i]) c[i] = {c[i][2:0], c[i][3] ^ c[i][0]};
            for (int i = 0; i < 16; i++) d[i] = c[ih[i]];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[63-4*i -: 4] = d[i];
        return r;
    endfunction

    // Submit one job and collect its ROUNDS+1 tweaks; optional stalls and
    // in_valid noise while the job runs.
    task automatic run_job(input logic [63:0] tw, input logic inv, input bit stall,
                           output seq_t seq);
        int          k        = 0;
        int          budget   = 0;
        int          stalls   = stall ? 5 : 0;
        bit          held     = 0;
        logic [63:0] h_tweak  = '0;
        logic [2:0]  h_idx    = '0;
        logic [63:0] model    = tw;
        bit          rdy;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("in_ready_before_job", {63'd0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_tweak   = tw;
        in_inverse = inv;
        out_ready  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        budget   = 0;
        while (k <= ROUNDS && budget < 100) begin
            budget++;
            chk("out_valid_run", {63'd0, out_valid}, 64'd1);
            chk("in_ready_run", {63'd0, in_ready}, 64'd0);
            chk("busy_run", {63'd0, busy}, 64'd1);
            if (held) begin
                chk("stall_tweak", out_tweak, h_tweak);
                chk("stall_idx", {61'd0, out_idx}, {61'd0, h_idx});
            end
            rdy = 1'b1;
            if (stalls > 0 && k >= 2 && ($urandom_range(0, 1) == 1 || k == ROUNDS)) begin
                rdy = 1'b0;
                stalls--;
            end
            out_ready = rdy;
            if (stall) begin
                in_valid   = 1'($urandom_range(0, 1));
                in_tweak   = {$urandom, $urandom};
                in_inverse = 1'($urandom_range(0, 1));
            end
            if (rdy) begin
                seq[k] = out_tweak;
                chk("idx", {61'd0, out_idx}, 64'(k));
                chk("last", {63'd0, out_last}, {63'd0, (k == ROUNDS)});
                chk("tweak_model", out_tweak, model);
                model = ref_upd(model, inv);
                k++;
                held = 0;
            end else begin
                held    = 1;
                h_tweak = out_tweak;
                h_idx   = out_idx;
            end
            @(negedge clk);
        end
        if (k <= ROUNDS) chk("job_timeout", 64'(k), 64'(ROUNDS + 1));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_after", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after", {63'd0, in_ready}, 64'd1);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("last_after", {63'd0, out_last}, 64'd0);
    endtask

    initial begin
        vec_t vecs [10];
        seq_t s, f, r, st;
        int   budget;

        vecs[0] = '{64'h0000_1000_0000_0000, 1'b0, 0, 64'h0000_1000_0000_0000};
        vecs[1] = '{64'h0000_1000_0000_0000, 1'b0, 1, 64'h0000_0000_0008_0000};
        vecs[2] = '{64'h0000_1000_0000_0000, 1'b0, 2, 64'h0000_0000_0000_0008};
        vecs[3] = '{64'h0000_1000_0000_0000, 1'b0, 3, 64'h0004_0000_0000_0000};
        vecs[4] = '{64'h0000_0000_0008_0000, 1'b1, 1, 64'h0000_1000_0000_0000};
        vecs[5] = '{64'h0004_0000_0000_0000, 1'b1, 1, 64'h0000_0000_0000_0008};
        vecs[6] = '{64'h0004_0000_0000_0000, 1'b1, 3, 64'h0000_1000_0000_0000};
        vecs[7] = '{64'h0000_0000_0000_0000, 1'b0, 4, 64'h0000_0000_0000_0000};
        vecs[8] = '{64'h0000_0000_0000_0000, 1'b0, 7, 64'h0000_0000_0000_0000};
        vecs[9] = '{64'h0000_0000_0000_0000, 1'b1, 7, 64'h0000_0000_0000_0000};

        // Reset with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_tweak   = {$urandom, $urandom};
            in_inverse = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_tweak", out_tweak, 64'd0);
            chk("rst_out_idx", {61'd0, out_idx}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 10; v++) begin
            run_job(vecs[v].tweak, vecs[v].inv, 1'b0, s);
            chk($sformatf("vec%0d_T%0d", v, vecs[v].k), s[vecs[v].k], vecs[v].exp);
        end

        // Round trip.
        run_job(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, f);
        run_job(f[ROUNDS], 1'b1, 1'b0, r);
        chk("roundtrip_final", r[ROUNDS], 64'h0123_4567_89AB_CDEF);
        for (int k = 0; k <= ROUNDS; k++)
            chk($sformatf("roundtrip_T%0d", k), r[ROUNDS-k], f[k]);

        // Backpressure with in_valid noise.
        run_job(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, st);
        for (int k = 0; k <= ROUNDS; k++)
            chk($sformatf("stall_seq_T%0d", k), st[k], f[k]);

        // Abort at idx 3.
        in_valid   = 1'b1;
        in_tweak   = 64'h0123_4567_89AB_CDEF;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        budget   = 0;
        while (out_idx != 3'd3 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("abort_reach_idx3", {61'd0, out_idx}, 64'd3);
        chk("abort_T3", out_tweak, f[3]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_out_idx", {61'd0, out_idx}, 64'd0);
        chk("abort_out_tweak", out_tweak, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("abort_idle_valid", {63'd0, out_valid}, 64'd0);
        run_job(64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, s);
        chk("post_abort_T0", s[0], 64'hFEDC_BA98_7654_3210);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
